// File: rtl/fighter_pkg.sv
// Shared state codes, attack-kind codes and default timing for the fighter FSM.
package fighter_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned PF_W    = 5;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_MOVE_FWD  = 3'd1;
    localparam logic [STATE_W-1:0] ST_MOVE_BWD  = 3'd2;
    localparam logic [STATE_W-1:0] ST_ATK_SU    = 3'd3;
    localparam logic [STATE_W-1:0] ST_ATK_ACT   = 3'd4;
    localparam logic [STATE_W-1:0] ST_ATK_REC   = 3'd5;
    localparam logic [STATE_W-1:0] ST_HITSTUN   = 3'd6;
    localparam logic [STATE_W-1:0] ST_BLOCKSTUN = 3'd7;

    localparam logic ATK_NEUTRAL = 1'b0;
    localparam logic ATK_DIR     = 1'b1;

    localparam int unsigned DEF_N_SU      = 4;
    localparam int unsigned DEF_N_ACT     = 1;
    localparam int unsigned DEF_N_REC     = 15;
    localparam int unsigned DEF_D_SU      = 3;
    localparam int unsigned DEF_D_ACT     = 2;
    localparam int unsigned DEF_D_REC     = 14;
    localparam int unsigned DEF_HITSTUN   = 15;
    localparam int unsigned DEF_BLOCKSTUN = 10;

    // Timed phases are the attack and stun states, all encoded at 3 and above.
    function automatic logic is_timed(input logic [STATE_W-1:0] s);
        return (s >= ST_ATK_SU);
    endfunction

    function automatic logic is_stun(input logic [STATE_W-1:0] s);
        return (s == ST_HITSTUN) || (s == ST_BLOCKSTUN);
    endfunction

endpackage

// File: rtl/fighter_fsm_if.sv
// Controller/fighter bundle: frame enable, buttons and hit in; position and status out.
interface fighter_fsm_if #(
    parameter int unsigned X_W = 10
);
    logic           frame_tick;
    logic           player;
    logic           btn_fwd;
    logic           btn_bwd;
    logic           btn_attack;
    logic           hit_in;
    logic [X_W-1:0] x_pos_opponent;
    logic [X_W-1:0] x_pos;
    logic [2:0]     state;
    logic           attack_kind;
    logic [4:0]     phase_frame;
    logic           hitbox_active;
    logic           hit_taken;

    modport master (
        output frame_tick, player, btn_fwd, btn_bwd, btn_attack, hit_in, x_pos_opponent,
        input  x_pos, state, attack_kind, phase_frame, hitbox_active, hit_taken
    );

    modport slave (
        input  frame_tick, player, btn_fwd, btn_bwd, btn_attack, hit_in, x_pos_opponent,
        output x_pos, state, attack_kind, phase_frame, hitbox_active, hit_taken
    );
endinterface

// File: rtl/fighter_fsm_phase_timer.sv
// Frame counter for timed phases: reloads on phase entry, flags the last frame.
module phase_timer #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] len_i,
    output logic [CNT_W-1:0] phase_frame_o,
    output logic             done_c_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;

    always_comb begin
        cnt_d = cnt_q;
        len_d = len_q;
        if (tick_i) begin
            if (load_i) begin
                cnt_d = '0;
                len_d = len_i;
            end else if (clear_i) begin
                cnt_d = '0;
            end else begin
                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

    assign phase_frame_o = cnt_q;
    assign done_c_o      = (cnt_q == CNT_W'(len_q - CNT_W'(1)));
endmodule

// File: rtl/fighter_fsm.sv
// One fighter: movement with opponent/screen clamping, attack phases and hit/block stun.
module fighter_fsm
    import fighter_pkg::*;
#(
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned SPRITE_W  = 64,
    parameter int unsigned X_W       = 10,
    parameter int unsigned START_OFS = 10,
    parameter int unsigned FWD_STEP  = 3,
    parameter int unsigned BWD_STEP  = 2,
    parameter int unsigned N_SU      = DEF_N_SU,
    parameter int unsigned N_ACT     = DEF_N_ACT,
    parameter int unsigned N_REC     = DEF_N_REC,
    parameter int unsigned D_SU      = DEF_D_SU,
    parameter int unsigned D_ACT     = DEF_D_ACT,
    parameter int unsigned D_REC     = DEF_D_REC,
    parameter int unsigned HITSTUN   = DEF_HITSTUN,
    parameter int unsigned BLOCKSTUN = DEF_BLOCKSTUN
) (
    input logic         clk,
    input logic         reset_n,
    fighter_fsm_if.slave bus
);
    localparam int unsigned XS_W = X_W + 1;

    logic [STATE_W-1:0] state_q, state_d;
    logic               kind_q, kind_d;
    logic [X_W-1:0]     x_q, x_d;
    logic               hitbox_q, hit_taken_q;
    logic               stun_entry;
    logic               t_load, t_clear, t_done;
    logic [PF_W-1:0]    t_len, phase_frame;

    logic signed [XS_W-1:0] x_s, opp_s, fwd_s, bwd_s, fwd_lim_s, bwd_lim_s;
    logic [X_W-1:0]         x_fwd, x_bwd;

    // Candidate positions for a forward/backward step, in signed space to avoid wrap.
    always_comb begin
        x_s   = $signed({1'b0, x_q});
        opp_s = $signed({1'b0, bus.x_pos_opponent});
        if (!bus.player) begin
            fwd_s     = x_s + $signed(XS_W'(FWD_STEP));
            fwd_lim_s = opp_s - $signed(XS_W'(SPRITE_W));
            bwd_s     = x_s - $signed(XS_W'(BWD_STEP));
            bwd_lim_s = '0;
            x_fwd = (x_s >= fwd_lim_s) ? x_q :
                    (fwd_s > fwd_lim_s) ? X_W'(fwd_lim_s) : X_W'(fwd_s);
            x_bwd = (bwd_s < bwd_lim_s) ? X_W'(bwd_lim_s) : X_W'(bwd_s);
        end else begin
            fwd_s     = x_s - $signed(XS_W'(FWD_STEP));
            fwd_lim_s = opp_s + $signed(XS_W'(SPRITE_W));
            bwd_s     = x_s + $signed(XS_W'(BWD_STEP));
            bwd_lim_s = $signed(XS_W'(SCREEN_W - SPRITE_W));
            x_fwd = (x_s <= fwd_lim_s) ? x_q :
                    (fwd_s < fwd_lim_s) ? X_W'(fwd_lim_s) : X_W'(fwd_s);
            x_bwd = (bwd_s > bwd_lim_s) ? X_W'(bwd_lim_s) : X_W'(bwd_s);
        end
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        x_d        = x_q;
        stun_entry = 1'b0;
        t_load     = 1'b0;
        t_clear    = 1'b0;
        t_len      = '0;
        if (bus.frame_tick) begin
            if (bus.hit_in && !is_stun(state_q)) begin
                state_d    = (state_q == ST_MOVE_BWD) ? ST_BLOCKSTUN : ST_HITSTUN;
                stun_entry = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE, ST_MOVE_FWD, ST_MOVE_BWD: begin
                        if (bus.btn_attack) begin
                            state_d = ST_ATK_SU;
                            kind_d  = (state_q == ST_IDLE) ? ATK_NEUTRAL : ATK_DIR;
                        end else if (bus.btn_fwd && !bus.btn_bwd) begin
                            state_d = ST_MOVE_FWD;
                        end else if (bus.btn_bwd && !bus.btn_fwd) begin
                            state_d = ST_MOVE_BWD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_ATK_SU:  if (t_done) state_d = ST_ATK_ACT;
                    ST_ATK_ACT: if (t_done) state_d = ST_ATK_REC;
                    default:    if (t_done) state_d = ST_IDLE;
                endcase
            end

            if (state_d == ST_MOVE_FWD)      x_d = x_fwd;
            else if (state_d == ST_MOVE_BWD) x_d = x_bwd;

            // Timer reloads on every phase change and sits at zero outside timed phases.
            t_load  = is_timed(state_d) && (state_d != state_q);
            t_clear = !is_timed(state_d);
            case (state_d)
                ST_ATK_SU:    t_len = kind_d ? PF_W'(D_SU)  : PF_W'(N_SU);
                ST_ATK_ACT:   t_len = kind_d ? PF_W'(D_ACT) : PF_W'(N_ACT);
                ST_ATK_REC:   t_len = kind_d ? PF_W'(D_REC) : PF_W'(N_REC);
                ST_HITSTUN:   t_len = PF_W'(HITSTUN);
                ST_BLOCKSTUN: t_len = PF_W'(BLOCKSTUN);
                default:      t_len = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            kind_q      <= ATK_NEUTRAL;
            x_q         <= bus.player ? X_W'(SCREEN_W - SPRITE_W - START_OFS) : X_W'(START_OFS);
            hitbox_q    <= 1'b0;
            hit_taken_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            x_q         <= x_d;
            hitbox_q    <= (state_d == ST_ATK_ACT);
            hit_taken_q <= stun_entry;
        end
    end

    phase_timer #(.CNT_W(PF_W)) u_timer (
        .clk           (clk),
        .rst_n         (reset_n),
        .tick_i        (bus.frame_tick),
        .load_i        (t_load),
        .clear_i       (t_clear),
        .len_i         (t_len),
        .phase_frame_o (phase_frame),
        .done_c_o      (t_done)
    );

    assign bus.x_pos         = x_q;
    assign bus.state         = state_q;
    assign bus.attack_kind   = kind_q;
    assign bus.phase_frame   = phase_frame;
    assign bus.hitbox_active = hitbox_q;
    assign bus.hit_taken     = hit_taken_q;
endmodule

// File: tb/tb_fighter_fsm.sv
// Directed, table-driven bench for fighter_fsm with hand-written multi-cycle corner cases.
module tb_fighter_fsm;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fighter_fsm_if #(.X_W(10)) bus ();
    fighter_fsm dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic fwd, bwd, atk, hit;
        int   st, x, pf;
        logic hb, ht;
        int   kind;   // -1 = not checked
    } vec_t;

    vec_t vq[$];
    int n_pass  = 0;
    int n_total = 0;

    function automatic void add(logic fwd, logic bwd, logic atk, logic hit,
                                int st, int x, int pf, logic hb, logic ht, int kind);
        vec_t v;
        v.fwd = fwd; v.bwd = bwd; v.atk = atk; v.hit = hit;
        v.st = st; v.x = x; v.pf = pf; v.hb = hb; v.ht = ht; v.kind = kind;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, got, exp);
    endtask

    task automatic chk_all(input string tag, input int st, input int x, input int pf,
                           input int hb, input int ht, input int kind);
        chk({tag, " state"}, int'(bus.state), st);
        chk({tag, " x_pos"}, int'(bus.x_pos), x);
        chk({tag, " phase_frame"}, int'(bus.phase_frame), pf);
        chk({tag, " hitbox"}, int'(bus.hitbox_active), hb);
        chk({tag, " hit_taken"}, int'(bus.hit_taken), ht);
        if (kind >= 0) chk({tag, " kind"}, int'(bus.attack_kind), kind);
    endtask

    task automatic set_btn(input logic fwd, input logic bwd, input logic atk, input logic hit);
        bus.btn_fwd = fwd; bus.btn_bwd = bwd; bus.btn_attack = atk; bus.hit_in = hit;
    endtask

    task automatic tick();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic do_reset(input logic p);
        bus.player = p;
        set_btn(0, 0, 0, 0);
        bus.frame_tick = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 0, p ? 566 : 10, 0, 0, 0, 0);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.x_pos_opponent = 10'd100;
        set_btn(0, 0, 0, 0);
        bus.frame_tick = 1'b0;
        bus.player = 1'b0;
        reset_n = 1'b0;

        // Player 0 walk/clamp, both-buttons idle, directional attack, hit in ATK_ACT.
        for (int i = 0; i < 8; i++) add(1, 0, 0, 0, 1, 13 + 3 * i, 0, 0, 0, -1);
        add(1, 0, 0, 0, 1, 36, 0, 0, 0, -1);
        add(1, 0, 0, 0, 1, 36, 0, 0, 0, -1);
        add(1, 1, 0, 0, 0, 36, 0, 0, 0, -1);
        add(0, 1, 0, 0, 2, 34, 0, 0, 0, -1);
        add(0, 1, 1, 0, 3, 34, 0, 0, 0, 1);
        add(0, 1, 0, 0, 3, 34, 1, 0, 0, 1);
        add(1, 0, 1, 0, 3, 34, 2, 0, 0, 1);
        add(0, 0, 0, 0, 4, 34, 0, 1, 0, 1);
        add(0, 0, 0, 1, 6, 34, 0, 0, 1, -1);
        for (int i = 1; i < 15; i++) add(1, 0, i[0], i[1], 6, 34, i, 0, 0, -1);
        add(1, 0, 0, 0, 0, 34, 0, 0, 0, -1);
        add(1, 0, 0, 0, 1, 36, 0, 0, 0, -1);

        do_reset(1'b0);
        foreach (vq[i]) begin
            set_btn(vq[i].fwd, vq[i].bwd, vq[i].atk, vq[i].hit);
            tick();
            chk_all($sformatf("vec%0d", i), vq[i].st, vq[i].x, vq[i].pf,
                    int'(vq[i].hb), int'(vq[i].ht), vq[i].kind);
        end

        // frame_tick low: held buttons must change nothing.
        set_btn(0, 1, 1, 1);
        repeat (5) @(negedge clk);
        chk_all("no_tick", 1, 36, 0, 0, 0, -1);

        // Neutral attack: 4 setup, 1 active, 15 recovery, then idle.
        do_reset(1'b0);
        set_btn(0, 0, 1, 0);
        tick();
        set_btn(0, 0, 0, 0);
        chk_all("natk t1", 3, 10, 0, 0, 0, 0);
        for (int t = 2; t <= 21; t++) begin
            tick();
            if (t <= 4)       chk_all($sformatf("natk t%0d", t), 3, 10, t - 1, 0, 0, 0);
            else if (t == 5)  chk_all("natk t5", 4, 10, 0, 1, 0, 0);
            else if (t <= 20) chk_all($sformatf("natk t%0d", t), 5, 10, t - 6, 0, 0, 0);
            else              chk_all("natk t21", 0, 10, 0, 0, 0, -1);
        end

        // Player 1 walking back to the right edge, then blocking.
        do_reset(1'b1);
        bus.x_pos_opponent = 10'd300;
        set_btn(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_all($sformatf("p1bwd%0d", i), 2, (i < 5) ? 568 + 2 * i : 576, 0, 0, 0, -1);
        end
        set_btn(0, 1, 0, 1);
        tick();
        chk_all("block entry", 7, 576, 0, 0, 1, -1);
        @(negedge clk);
        chk("block pulse end", int'(bus.hit_taken), 0);
        for (int i = 1; i < 10; i++) begin
            tick();
            chk_all($sformatf("block%0d", i), 7, 576, i, 0, 0, -1);
        end
        tick();
        chk_all("block exit", 0, 576, 0, 0, 0, -1);

        // Asynchronous reset in the middle of recovery, then a clean start from idle.
        do_reset(1'b0);
        bus.x_pos_opponent = 10'd100;
        set_btn(0, 0, 1, 0);
        tick();
        set_btn(0, 0, 0, 0);
        repeat (6) tick();
        chk_all("rec before rst", 5, 10, 1, 0, 0, 0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk_all("async rst", 0, 10, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        set_btn(1, 0, 0, 0);
        tick();
        chk_all("post rst", 1, 13, 0, 0, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fighter_fsm.md
FIGHTER_FSM -- requirements
Module: fighter_fsm

Interface
REQ-001 Parameters SHALL be: SCREEN_W 640, screen width px; SPRITE_W 64, sprite width px; X_W 10, position width; START_OFS 10, reset gap from own edge; FWD_STEP 3, forward px/frame; BWD_STEP 2, backward px/frame.
REQ-002 Timing parameters SHALL be: N_SU 4, N_ACT 1, N_REC 15 (neutral attack); D_SU 3, D_ACT 2, D_REC 14 (directional attack); HITSTUN 15; BLOCKSTUN 10 (frames, each >=1).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active low
- frame_tick  in  1  one-cycle 60 Hz frame enable
- player  in  1  0 = left fighter, 1 = right fighter; static after reset
- btn_fwd  in  1  toward-opponent held
- btn_bwd  in  1  away-from-opponent held
- btn_attack  in  1  attack held
- hit_in  in  1  opponent hitbox overlaps this hurtbox this frame
- x_pos_opponent  in  X_W  opponent top-left X
- x_pos  out  X_W  own top-left X
- state  out  3  current state code
- attack_kind  out  1  0 = neutral, 1 = directional
- phase_frame  out  5  frames elapsed in current timed phase
- hitbox_active  out  1  high only in ATK_ACT
- hit_taken  out  1  one-cycle pulse when hitstun/blockstun entered

Function
REQ-005 All state, position and counter updates SHALL occur only on clk edges with frame_tick=1; otherwise registers hold.
REQ-006 States SHALL be IDLE 0, MOVE_FWD 1, MOVE_BWD 2, ATK_SU 3, ATK_ACT 4, ATK_REC 5, HITSTUN 6, BLOCKSTUN 7.
REQ-007 Tick priority SHALL be hit_in > btn_attack > movement buttons.
REQ-008 hit_in in MOVE_BWD SHALL enter BLOCKSTUN; in any other non-stun state, HITSTUN (aborting attacks, hitbox_active drops same tick); ignored in HITSTUN/BLOCKSTUN.
REQ-009 btn_attack in IDLE SHALL enter ATK_SU, attack_kind=0; in MOVE_FWD/MOVE_BWD, ATK_SU, attack_kind=1.
REQ-010 In IDLE/MOVE_*: btn_fwd alone -> MOVE_FWD; btn_bwd alone -> MOVE_BWD; both or neither -> IDLE.
REQ-011 Each timed phase SHALL last exactly its parameter in ticks; phase_frame SHALL be 0 on entry, +1 per tick, transition on the tick where phase_frame = length-1.
REQ-012 Sequence SHALL be ATK_SU -> ATK_ACT -> ATK_REC -> IDLE, stun -> IDLE; buttons ignored in all timed phases.
REQ-013 On a tick whose next state is MOVE_FWD, x SHALL move FWD_STEP toward opponent, clamped to x_pos_opponent-SPRITE_W (player 0) or x_pos_opponent+SPRITE_W (player 1); if already closer, x holds (never moves away).
REQ-014 On a tick whose next state is MOVE_BWD, x SHALL move BWD_STEP away, clamped to 0 (player 0) or SCREEN_W-SPRITE_W (player 1).
REQ-015 Position arithmetic SHALL use X_W+1-bit signed intermediates; no wrap-around at 0 or SCREEN_W.
REQ-016 hit_taken SHALL pulse for exactly one clk cycle coincident with the stun-entry edge.
REQ-017 phase_frame SHALL read 0 outside timed phases.

Reset
REQ-018 On reset_n=0, immediately: state IDLE, attack_kind 0, phase_frame 0, hitbox_active 0, hit_taken 0, x_pos START_OFS (player 0) or SCREEN_W-SPRITE_W-START_OFS (player 1).
REQ-019 Reset mid-attack or mid-stun SHALL abandon the phase; first post-release tick behaves as from IDLE.

Structure
REQ-020 Package fighter_pkg SHALL hold state codes, attack-kind codes and default timing constants.
REQ-021 Sub-module phase_timer (load length, count on frame_tick, done flag, phase_frame output) SHALL implement REQ-011.

Verification
REQ-022 Reset, player=0, IDLE, btn_attack 1 tick -> ATK_SU 4 ticks, ATK_ACT 1 (hitbox_active=1), ATK_REC 15, IDLE; total 20 ticks.
REQ-023 player=0, x=10, btn_fwd held, opponent 100 -> x 13,16,19,22,25,28,31,34,36, then holds 36.
REQ-024 player=1, x=570, btn_bwd held -> 572,574,576, holds 576; hit_in during -> BLOCKSTUN 10 ticks, hit_taken one pulse.
REQ-025 hit_in during ATK_ACT (directional) -> HITSTUN, hitbox_active 0 same tick, IDLE after 15 ticks.
REQ-026 btn_fwd+btn_bwd held -> IDLE, x unchanged; frame_tick low -> nothing changes.
REQ-027 reset_n low during ATK_REC -> outputs at reset values within the cycle, asynchronously.
